// File: rtl/pipeline_pkg.sv
// Shared types, field positions and helpers for the front-end issue datapath.
// Instruction layout: op[2:0] rd[5:3] rs1[8:6] rs2[11:9] imm16[27:12].
package pipeline_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned REG_W   = 3;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned SB_W    = 2;

   localparam int unsigned OP_LSB  = 0;
   localparam int unsigned RD_LSB  = 3;
   localparam int unsigned RS1_LSB = 6;
   localparam int unsigned RS2_LSB = 9;
   localparam int unsigned IMM_LSB = 12;
   localparam int unsigned DEC_W   = 28;

   localparam logic [SB_W-1:0] SB_MAX = 2'd3;

   typedef enum logic [OP_W-1:0] {
      ADD   = 3'd0,
      SUB   = 3'd1,
      AND   = 3'd2,
      OR    = 3'd3,
      XOR   = 3'd4,
      SLL   = 3'd5,
      SRL   = 3'd6,
      LOADI = 3'd7
   } op_e;

   typedef struct packed {
      op_e              op;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [IMM_W-1:0] imm;
   } dec_t;

   // LOADI is the only op that reads no register.
   function automatic logic uses_srcs(input op_e op);
      return op != LOADI;
   endfunction

   function automatic dec_t decode(input logic [DEC_W-1:0] w);
      dec_t d;
      d.op  = op_e'(w[OP_LSB +: OP_W]);
      d.rd  = w[RD_LSB +: REG_W];
      d.rs1 = w[RS1_LSB +: REG_W];
      d.rs2 = w[RS2_LSB +: REG_W];
      d.imm = w[IMM_LSB +: IMM_W];
      return d;
   endfunction

   // Pending count after a same-cycle writeback is retired; a writeback at zero retires nothing.
   function automatic logic src_pending(input logic [SB_W-1:0] cnt, input logic wb_hit);
      return cnt > SB_W'(wb_hit);
   endfunction

endpackage

// File: rtl/issue_stage_if.sv
// Instruction-in, issue-out and writeback bus of the issue stage.
// The slave side is the issue stage; the master side is its environment.
interface issue_stage_if;
   import pipeline_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_instr;

   logic             iss_valid;
   logic [OP_W-1:0]  iss_op;
   logic [REG_W-1:0] iss_rd;
   logic [XLEN-1:0]  iss_src1;
   logic [XLEN-1:0]  iss_src2;
   logic [XLEN-1:0]  iss_imm;

   logic             wb_en;
   logic [REG_W-1:0] wb_rd;
   logic [XLEN-1:0]  wb_data;

   modport master (
      output in_valid, in_instr, wb_en, wb_rd, wb_data,
      input  in_ready, iss_valid, iss_op, iss_rd, iss_src1, iss_src2, iss_imm
   );

   modport slave (
      input  in_valid, in_instr, wb_en, wb_rd, wb_data,
      output in_ready, iss_valid, iss_op, iss_rd, iss_src1, iss_src2, iss_imm
   );

endinterface

// File: rtl/issue_fifo.sv
// Instruction queue in front of decode. The pointers carry one extra wrap bit so
// full and empty are told apart by the MSB; a full queue never accepts, even on a pop.
module issue_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_en;
   logic             pop_en;

   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty     = (wr_ptr == rd_ptr);
   assign count     = wr_ptr - rd_ptr;
   assign head_data = mem[rd_ptr[AW-1:0]];
   assign push_en   = push && !full && !flush;
   assign pop_en    = pop && !empty && !flush;

   // Pointer update; flush empties the queue by catching the read pointer up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/issue_stage.sv
// Issue stage: queues instruction words, decodes the head, reads the local register
// file with writeback bypass and holds issue while a source has a write in flight.
module issue_stage
   import pipeline_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned NREGS = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   issue_stage_if.slave           bus,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [XLEN-1:0]        stall_cnt
);

   logic [XLEN-1:0] head_word;
   logic            fifo_full;
   logic            fifo_empty;
   logic            head_valid;
   logic            push;
   logic            hazard_c;
   logic            issue_c;
   logic            stall_c;
   logic            wb_hit1;
   logic            wb_hit2;
   logic [XLEN-1:0] opnd1;
   logic [XLEN-1:0] opnd2;
   logic            unused_hi;
   dec_t            head;

   logic [SB_W-1:0] sb_cnt  [NREGS];
   logic [SB_W-1:0] sb_next [NREGS];
   logic [XLEN-1:0] rf      [NREGS];

   assign bus.in_ready = !fifo_full && !flush;
   assign push         = bus.in_valid && bus.in_ready;
   assign head_valid   = !fifo_empty;

   issue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (bus.in_instr),
      .pop       (issue_c),
      .flush     (flush),
      .head_data (head_word),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Bits above imm16 carry no meaning for this stage.
   assign head      = decode(head_word[DEC_W-1:0]);
   assign unused_hi = ^head_word[XLEN-1:DEC_W];

   // Hazard check and operand read, both seeing a same-cycle writeback.
   always_comb begin
      wb_hit1  = bus.wb_en && (bus.wb_rd == head.rs1);
      wb_hit2  = bus.wb_en && (bus.wb_rd == head.rs2);
      hazard_c = (uses_srcs(head.op) &&
                  (src_pending(sb_cnt[head.rs1], wb_hit1) ||
                   src_pending(sb_cnt[head.rs2], wb_hit2))) ||
                 (sb_cnt[head.rd] == SB_MAX);
      issue_c  = head_valid && !hazard_c && !flush;
      stall_c  = head_valid &&  hazard_c && !flush;
      opnd1    = wb_hit1 ? bus.wb_data : rf[head.rs1];
      opnd2    = wb_hit2 ? bus.wb_data : rf[head.rs2];
   end

   // Scoreboard next state: issue and writeback to the same register cancel out.
   always_comb begin
      logic inc;
      logic dcr;
      inc = 1'b0;
      dcr = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         inc        = issue_c && (head.rd == REG_W'(r));
         dcr        = bus.wb_en && (bus.wb_rd == REG_W'(r));
         sb_next[r] = sb_cnt[r];
         if (inc && !dcr) begin
            sb_next[r] = sb_cnt[r] + SB_W'(1);
         end else if (dcr && !inc && (sb_cnt[r] != '0)) begin
            sb_next[r] = sb_cnt[r] - SB_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            rf[r]     <= '0;
            sb_cnt[r] <= '0;
         end
      end else begin
         sb_cnt <= sb_next;
         if (bus.wb_en) rf[bus.wb_rd] <= bus.wb_data;
      end
   end

   // Issue registers hold their payload when nothing issues; only the valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.iss_valid <= 1'b0;
         bus.iss_op    <= '0;
         bus.iss_rd    <= '0;
         bus.iss_src1  <= '0;
         bus.iss_src2  <= '0;
         bus.iss_imm   <= '0;
         stall_cnt     <= '0;
      end else begin
         bus.iss_valid <= issue_c;
         if (issue_c) begin
            bus.iss_op   <= OP_W'(head.op);
            bus.iss_rd   <= head.rd;
            bus.iss_src1 <= opnd1;
            bus.iss_src2 <= opnd2;
            bus.iss_imm  <= XLEN'(head.imm);
         end
         if (stall_c) stall_cnt <= stall_cnt + XLEN'(1);
      end
   end

endmodule
